arb_rr_4: RTL and testbench

Four-requester round-robin arbiter with grant hold, release and timeout, sharing one downstream resource. It registers a 2-bit owner index and expands it to a one-hot grant through one instance of the existing `Decoder_2_4` cell-level decoder. It sits between four requesting agents and the shared resource, and is the only block allowed to drive that resource's select lines.

---
 rtl/arb_rr_4_pkg.sv | 14 +
 rtl/arb_rr_4_dec.sv | 13 +
 rtl/arb_rr_4.sv | 106 ++++++++++
 tb/tb_arb_rr_4.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arb_rr_4_pkg.sv
// arb_rr_4 shared types and constants.
// State encoding, requester count and index width.
package arb_rr_4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr_4_dec.sv
// Cell-level 2-to-4 one-hot decoder.
// Pure gates; the arbiter masks the output with its valid flag.
module Decoder_2_4 (
  input  logic [1:0] a_i,
  output logic [3:0] y_o
);

  assign y_o[0] = ~a_i[1] & ~a_i[0];
  assign y_o[1] = ~a_i[1] &  a_i[0];
  assign y_o[2] =  a_i[1] & ~a_i[0];
  assign y_o[3] =  a_i[1] &  a_i[0];

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with grant hold limit,
// release pulse and a one-cycle break-before-make gap.
module arb_rr_4
  import arb_rr_4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HLIM = CW'(HOLD_MAX - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 vld_q;
  logic                 to_q;
  logic [CW-1:0]        cnt_q;
  logic [IDX_W-1:0]     pick_d;
  logic                 exit_d;
  logic                 tmo_d;
  logic [NREQ-1:0]      dec_y;

  // First asserted request at or after the pointer, wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NREQ-1:0]  r,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W-1:0] k;
    logic             hit;
    rr_pick = p;
    hit     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = p + IDX_W'(i);
      if (!hit && r[k]) begin
        rr_pick = k;
        hit     = 1'b1;
      end
    end
  endfunction

  always_comb begin
    pick_d = rr_pick(req, ptr_q);
    exit_d = done || !req[idx_q] || (cnt_q == HLIM);
    tmo_d  = !done && req[idx_q] && (cnt_q == HLIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            idx_q   <= pick_d;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != HLIM)
            cnt_q <= cnt_q + 1'b1;
          if (exit_d) begin
            ptr_q   <= idx_q + 1'b1;
            vld_q   <= 1'b0;
            to_q    <= tmo_d;
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  Decoder_2_4 u_dec (
    .a_i (idx_q),
    .y_o (dec_y)
  );

  assign gnt       = dec_y & {NREQ{vld_q}};
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Scoreboard bench for arb_rr_4 with HOLD_MAX = 8.
// Driver queues expected outputs; a monitor compares them.
module tb_arb_rr_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [3:0] g;
    logic [1:0] i;
    logic       t;
  } exp_t;

  exp_t sb[$];

  arb_rr_4 #(.HOLD_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: compare each queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.nm, ".gnt"}, int'(gnt), int'(e.g));
        chk({e.nm, ".vld"}, int'(gnt_valid), int'(|e.g));
        chk({e.nm, ".tmo"}, int'(timeout), int'(e.t));
        if (|e.g)
          chk({e.nm, ".idx"}, int'(gnt_idx), int'(e.i));
      end
    end
  end

  task automatic cyc(
    input string      nm,
    input logic [3:0] r,
    input logic       d,
    input logic [3:0] g,
    input logic [1:0] i,
    input logic       t
  );
    exp_t e;
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    e.nm = nm;
    e.g  = g;
    e.i  = i;
    e.t  = t;
    sb.push_back(e);
  endtask

  logic [3:0] tog [7];

  initial begin
    tog = '{4'b1110, 4'b0101, 4'b1100, 4'b0110,
            4'b1111, 4'b0100, 4'b1101};
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt", int'(gnt), 0);
    chk("rst.vld", int'(gnt_valid), 0);
    chk("rst.idx", int'(gnt_idx), 0);
    chk("rst.tmo", int'(timeout), 0);
    rst = 1'b0;

    // single requester, release, pointer moves to 3
    cyc("t1.gnt", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc("t1.rel", 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("t1.gap", 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("t1.ptr", 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);

    // full contention with done every grant: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      cyc("t2.rel", 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
      cyc("t2.gap", 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
      cyc("t2.gnt", 4'b1111, 1'b0,
          4'b0001 << (k % 4), 2'(k % 4), 1'b0);
    end
    cyc("t2.end", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("t2.gap", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("t2.idl", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // hold limit: grant lasts 8 cycles, then timeout
    cyc("t3.gnt", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 7; k++)
      cyc("t3.hold", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("t3.tmo", 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1);
    cyc("t3.idl", 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("t3.rgnt", 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("t3.aban", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("t3.gap", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // done and drop at the limit: single exit, no timeout
    cyc("t4.gnt", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    for (int k = 0; k < 7; k++)
      cyc("t4.hold", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("t4.exit", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("t4.gap", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // non-owner toggling leaves the hold sequence intact
    cyc("t6.gnt", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    for (int k = 0; k < 7; k++)
      cyc("t6.tog", tog[k], 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc("t6.tmo", 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1);
    cyc("t6.idl", 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // asynchronous reset while agent 2 owns the grant
    cyc("t5.gnt", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc("t5.hold", 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5.async.gnt", int'(gnt), 0);
    chk("t5.async.vld", int'(gnt_valid), 0);
    chk("t5.async.tmo", int'(timeout), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("t5.rgnt", 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("t5.rel", 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    chk("sb.drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
